regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the MIPS core, the successor to the fixed 2-read/1-write register file. It provides N combinational read ports with write-through bypass and two write ports: A for ALU/EX writeback and B for load/long-latency writeback. It also holds a per-register busy scoreboard that ID uses to detect load-use and long-latency hazards. It sits between ID (reads, reservations) and WB (writes).

---
 rtl/regfile_mp_pkg.sv | 18 +
 rtl/regfile_mp_scoreboard.sv | 67 ++++++
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// The widths and reset levels used by regfile_mp and its scoreboard live here.
package regfile_mp_pkg;

  localparam int unsigned REG_BUS_W      = 32;
  localparam int unsigned REG_NUM        = 32;
  localparam int unsigned REG_ADDR_BUS_W = $clog2(REG_NUM);
  localparam int unsigned RD_PORTS       = 2;

  localparam logic RST_ENABLE  = 1'b0;
  localparam logic RST_DISABLE = 1'b1;

  // Register 0 is inert (never written, never busy, reads zero) when hardwired.
  function automatic logic is_hardwired(input bit zero_reg, input int unsigned addr);
    return zero_reg && (addr == 32'd0);
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Busy-bit scoreboard: one reservation bit per register plus a running count
// of reserved registers, kept incrementally rather than by popcount.
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned NUM_REGS = REG_NUM,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rsv_en_i,
  input  logic [ADDR_W-1:0]   rsv_addr_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic                flush_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [CNT_W-1:0]    pend_cnt_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsv_ok_s, inc_s, dec_s;

  // A reservation to the same register as a port-B clear wins, so no decrement.
  assign rsv_ok_s = rsv_en_i && !is_hardwired(ZERO_REG, 32'(rsv_addr_i));
  assign inc_s    = rsv_ok_s && !busy_q[rsv_addr_i];
  assign dec_s    = wb_we_i && busy_q[wb_addr_i] && !(rsv_ok_s && (rsv_addr_i == wb_addr_i));

  // Next busy vector and pending count: flush, then reserve over clear.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (wb_we_i) begin
        busy_d[wb_addr_i] = 1'b0;
      end else begin
        busy_d[wb_addr_i] = busy_d[wb_addr_i];
      end
      if (rsv_ok_s) begin
        busy_d[rsv_addr_i] = 1'b1;
      end else begin
        busy_d[rsv_addr_i] = busy_d[rsv_addr_i];
      end
      cnt_d = cnt_q + CNT_W'(inc_s) - CNT_W'(dec_s);
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: NUM_RD combinational read ports with write-through
// bypass, two write ports (B wins on collision) and a busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = REG_BUS_W,
  parameter int unsigned NUM_REGS = REG_NUM,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = RD_PORTS,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_we,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [CNT_W-1:0]         pend_cnt
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec_s;
  logic                wa_ok_s, wb_ok_s;

  assign wa_ok_s = wa_we && !is_hardwired(ZERO_REG, 32'(wa_addr));
  assign wb_ok_s = wb_we && !is_hardwired(ZERO_REG, 32'(wb_addr));

  // Next register contents; port B is applied last so it wins a collision.
  always_comb begin
    regs_d = regs_q;
    if (wa_ok_s) begin
      regs_d[wa_addr] = wa_data;
    end else begin
      regs_d[wa_addr] = regs_d[wa_addr];
    end
    if (wb_ok_s) begin
      regs_d[wb_addr] = wb_data;
    end else begin
      regs_d[wb_addr] = regs_d[wb_addr];
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  regfile_mp_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .wb_we_i    (wb_we),
    .wb_addr_i  (wb_addr),
    .flush_i    (flush),
    .busy_o     (busy_vec_s),
    .pend_cnt_o (pend_cnt)
  );

  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              busy_s;

    assign addr_s = rd_addr[i*ADDR_W +: ADDR_W];

    // Read mux: zero register, then port-B bypass (which also hides busy), then A, then storage.
    always_comb begin
      data_s = '0;
      busy_s = 1'b0;
      if ((rst == RST_ENABLE) || is_hardwired(ZERO_REG, 32'(addr_s))) begin
        data_s = '0;
        busy_s = 1'b0;
      end else if (wb_we && (wb_addr == addr_s)) begin
        data_s = wb_data;
        busy_s = 1'b0;
      end else if (wa_we && (wa_addr == addr_s)) begin
        data_s = wa_data;
        busy_s = busy_vec_s[addr_s];
      end else begin
        data_s = regs_q[addr_s];
        busy_s = busy_vec_s[addr_s];
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data_s;
    assign rd_busy[i]                  = busy_s;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: default regfile_mp (u0) and a 4-read/16-reg/64-bit
// no-zero-register variant (u1), both checked every cycle against a model.
module tb_regfile_mp;

  logic clk;
  logic rst;

  logic [9:0]  rd_addr0;
  logic [63:0] rd_data0;
  logic [1:0]  rd_busy0;
  logic        wa_we0, wb_we0, rsv_en0, flush0;
  logic [4:0]  wa_addr0, wb_addr0, rsv_addr0;
  logic [31:0] wa_data0, wb_data0;
  logic [5:0]  pend_cnt0;

  logic [15:0]  rd_addr1;
  logic [255:0] rd_data1;
  logic [3:0]   rd_busy1;
  logic         wa_we1, wb_we1, rsv_en1, flush1;
  logic [3:0]   wa_addr1, wb_addr1, rsv_addr1;
  logic [63:0]  wa_data1, wb_data1;
  logic [4:0]   pend_cnt1;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  regfile_mp u0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wa_we(wa_we0), .wa_addr(wa_addr0), .wa_data(wa_data0),
    .wb_we(wb_we0), .wb_addr(wb_addr0), .wb_data(wb_data0),
    .rsv_en(rsv_en0), .rsv_addr(rsv_addr0), .flush(flush0), .pend_cnt(pend_cnt0)
  );

  regfile_mp #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4), .ZERO_REG(1'b0)) u1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wa_we(wa_we1), .wa_addr(wa_addr1), .wa_data(wa_data1),
    .wb_we(wb_we1), .wb_addr(wb_addr1), .wb_data(wb_data1),
    .rsv_en(rsv_en1), .rsv_addr(rsv_addr1), .flush(flush1), .pend_cnt(pend_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: architectural register values and the set of busy registers.
  logic [31:0] m0_r [32];
  logic [31:0] m0_b;
  logic [63:0] m1_r [16];
  logic [15:0] m1_b;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 32; k++) m0_r[k] = 32'd0;
      for (int k = 0; k < 16; k++) m1_r[k] = 64'd0;
      m0_b = 32'd0;
      m1_b = 16'd0;
    end else begin
      if (wa_we0 && wa_addr0 != 5'd0) m0_r[wa_addr0] = wa_data0;
      if (wb_we0 && wb_addr0 != 5'd0) m0_r[wb_addr0] = wb_data0;
      if (flush0) m0_b = 32'd0;
      else begin
        if (wb_we0) m0_b[wb_addr0] = 1'b0;
        if (rsv_en0 && rsv_addr0 != 5'd0) m0_b[rsv_addr0] = 1'b1;
      end
      if (wa_we1) m1_r[wa_addr1] = wa_data1;
      if (wb_we1) m1_r[wb_addr1] = wb_data1;
      if (flush1) m1_b = 16'd0;
      else begin
        if (wb_we1) m1_b[wb_addr1] = 1'b0;
        if (rsv_en1) m1_b[rsv_addr1] = 1'b1;
      end
    end
  end

  function automatic logic [31:0] e0_data(input logic [4:0] a);
    if (!rst || a == 5'd0) return 32'd0;
    if (wb_we0 && wb_addr0 == a) return wb_data0;
    if (wa_we0 && wa_addr0 == a) return wa_data0;
    return m0_r[a];
  endfunction

  function automatic logic e0_busy(input logic [4:0] a);
    if (!rst || a == 5'd0) return 1'b0;
    return m0_b[a] && !(wb_we0 && wb_addr0 == a);
  endfunction

  function automatic logic [63:0] e1_data(input logic [3:0] a);
    if (!rst) return 64'd0;
    if (wb_we1 && wb_addr1 == a) return wb_data1;
    if (wa_we1 && wa_addr1 == a) return wa_data1;
    return m1_r[a];
  endfunction

  function automatic logic e1_busy(input logic [3:0] a);
    if (!rst) return 1'b0;
    return m1_b[a] && !(wb_we1 && wb_addr1 == a);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("u0_rd_data", 64'(rd_data0[i*32 +: 32]), 64'(e0_data(rd_addr0[i*5 +: 5])));
        check("u0_rd_busy", 64'(rd_busy0[i]), 64'(e0_busy(rd_addr0[i*5 +: 5])));
      end
      check("u0_pend_cnt", 64'(pend_cnt0), rst ? 64'($countones(m0_b)) : 64'd0);
      for (int i = 0; i < 4; i++) begin
        check("u1_rd_data", rd_data1[i*64 +: 64], e1_data(rd_addr1[i*4 +: 4]));
        check("u1_rd_busy", 64'(rd_busy1[i]), 64'(e1_busy(rd_addr1[i*4 +: 4])));
      end
      check("u1_pend_cnt", 64'(pend_cnt1), rst ? 64'($countones(m1_b)) : 64'd0);
    end
  end

  task automatic clr();
    rd_addr0 = 10'd0; wa_we0 = 1'b0; wa_addr0 = 5'd0; wa_data0 = 32'd0;
    wb_we0 = 1'b0; wb_addr0 = 5'd0; wb_data0 = 32'd0;
    rsv_en0 = 1'b0; rsv_addr0 = 5'd0; flush0 = 1'b0;
    rd_addr1 = 16'd0; wa_we1 = 1'b0; wa_addr1 = 4'd0; wa_data1 = 64'd0;
    wb_we1 = 1'b0; wb_addr1 = 4'd0; wb_data1 = 64'd0;
    rsv_en1 = 1'b0; rsv_addr1 = 4'd0; flush1 = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic rnd();
    wa_we0 = 1'($urandom); wa_addr0 = 5'($urandom); wa_data0 = $urandom;
    wb_we0 = 1'($urandom); wb_addr0 = 5'($urandom); wb_data0 = $urandom;
    rsv_en0 = ($urandom_range(0, 2) == 0); rsv_addr0 = 5'($urandom);
    flush0 = ($urandom_range(0, 15) == 0);
    rd_addr0 = 10'($urandom);
    if ($urandom_range(0, 3) == 0) rd_addr0[4:0] = wb_addr0;
    if ($urandom_range(0, 3) == 0) rd_addr0[9:5] = wa_addr0;
    wa_we1 = 1'($urandom); wa_addr1 = 4'($urandom); wa_data1 = {$urandom, $urandom};
    wb_we1 = 1'($urandom); wb_addr1 = 4'($urandom); wb_data1 = {$urandom, $urandom};
    rsv_en1 = ($urandom_range(0, 2) == 0); rsv_addr1 = 4'($urandom);
    flush1 = ($urandom_range(0, 15) == 0);
    rd_addr1 = 16'($urandom);
    if ($urandom_range(0, 3) == 0) rd_addr1[3:0] = wb_addr1;
    if ($urandom_range(0, 3) == 0) rd_addr1[7:4] = wa_addr1;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_data", rd_data0, 64'd0);
    check("rst_busy", 64'(rd_busy0), 64'd0);
    check("rst_pend", 64'(pend_cnt0), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    step(); wa_we0 = 1'b1; wa_addr0 = 5'd3; wa_data0 = 32'hDEADBEEF; rd_addr0 = {5'd0, 5'd3};
    @(negedge clk); check("byp_wa", 64'(rd_data0[31:0]), 64'hDEADBEEF);
    step(); rd_addr0 = {5'd0, 5'd3};
    @(negedge clk); check("stored_r3", 64'(rd_data0[31:0]), 64'hDEADBEEF);
    step(); wa_we0 = 1'b1; wa_addr0 = 5'd0; wa_data0 = 32'h1234; rd_addr0 = {5'd0, 5'd0};
    @(negedge clk); check("r0_byp", 64'(rd_data0[31:0]), 64'd0);
    step(); rd_addr0 = {5'd0, 5'd0};
    @(negedge clk); check("r0_stored", 64'(rd_data0[31:0]), 64'd0);
    step(); wa_we0 = 1'b1; wa_addr0 = 5'd7; wa_data0 = 32'h11;
    wb_we0 = 1'b1; wb_addr0 = 5'd7; wb_data0 = 32'h22; rd_addr0 = {5'd7, 5'd7};
    @(negedge clk); check("coll_byp", 64'(rd_data0[63:32]), 64'h22);
    step(); rd_addr0 = {5'd0, 5'd7};
    @(negedge clk); check("coll_stored", 64'(rd_data0[31:0]), 64'h22);
    step(); rsv_en0 = 1'b1; rsv_addr0 = 5'd9; rd_addr0 = {5'd9, 5'd0};
    @(negedge clk); check("rsv_latency", 64'(rd_busy0[1]), 64'd0);
    step(); rd_addr0 = {5'd9, 5'd0};
    @(negedge clk); check("rsv_busy", 64'(rd_busy0[1]), 64'd1); check("rsv_cnt", 64'(pend_cnt0), 64'd1);
    step(); wb_we0 = 1'b1; wb_addr0 = 5'd9; wb_data0 = 32'h55; rd_addr0 = {5'd9, 5'd0};
    @(negedge clk); check("clr_busy", 64'(rd_busy0[1]), 64'd0);
    check("clr_data", 64'(rd_data0[63:32]), 64'h55); check("clr_cnt_pre", 64'(pend_cnt0), 64'd1);
    step(); rd_addr0 = {5'd9, 5'd0};
    @(negedge clk); check("clr_cnt", 64'(pend_cnt0), 64'd0); check("clr_stored", 64'(rd_data0[63:32]), 64'h55);
    step(); rsv_en0 = 1'b1; rsv_addr0 = 5'd4;
    step(); rsv_en0 = 1'b1; rsv_addr0 = 5'd4; wb_we0 = 1'b1; wb_addr0 = 5'd4; wb_data0 = 32'h66;
    rd_addr0 = {5'd0, 5'd4};
    @(negedge clk); check("same_clr_vis", 64'(rd_busy0[0]), 64'd0);
    step(); rd_addr0 = {5'd0, 5'd4};
    @(negedge clk); check("same_busy", 64'(rd_busy0[0]), 64'd1); check("same_cnt", 64'(pend_cnt0), 64'd1);
    step(); rsv_en0 = 1'b1; rsv_addr0 = 5'd0;
    step(); rd_addr0 = {5'd0, 5'd0};
    @(negedge clk); check("r0_rsv_busy", 64'(rd_busy0[0]), 64'd0); check("r0_rsv_cnt", 64'(pend_cnt0), 64'd1);
    step(); rsv_en0 = 1'b1; rsv_addr0 = 5'd2; flush0 = 1'b1;
    step(); rd_addr0 = {5'd4, 5'd2};
    @(negedge clk); check("flush_busy", 64'(rd_busy0), 64'd0); check("flush_cnt", 64'(pend_cnt0), 64'd0);

    step(); wa_we1 = 1'b1; wa_addr1 = 4'd0; wa_data1 = 64'hA5A5A5A5A5A5A5A5;
    wb_we1 = 1'b1; wb_addr1 = 4'd15; wb_data1 = 64'h0123456789ABCDEF; rsv_en1 = 1'b1; rsv_addr1 = 4'd0;
    step(); rd_addr1 = {4'd3, 4'd0, 4'd15, 4'd0};
    @(negedge clk);
    check("p4_rd0", rd_data1[63:0], 64'hA5A5A5A5A5A5A5A5);
    check("p4_rd1", rd_data1[127:64], 64'h0123456789ABCDEF);
    check("p4_rd2", rd_data1[191:128], 64'hA5A5A5A5A5A5A5A5);
    check("p4_rd3", rd_data1[255:192], 64'd0);
    check("p4_r0_busy", 64'(rd_busy1), 64'b0101);
    check("p4_cnt", 64'(pend_cnt1), 64'd1);

    for (int c = 0; c < 1500; c++) begin
      step();
      rnd();
    end

    step(); rnd();
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_data", rd_data0, 64'd0);
    check("mid_rst_busy", 64'(rd_busy0), 64'd0);
    check("mid_rst_cnt", 64'(pend_cnt0), 64'd0);
    check("mid_rst_cnt1", 64'(pend_cnt1), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clr();
    rd_addr0 = {5'd0, 5'd5};
    @(negedge clk); check("post_rst_r5", 64'(rd_data0[31:0]), 64'd0);

    for (int c = 0; c < 300; c++) begin
      step();
      rnd();
    end
    step();
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
